// File: rtl/dekatron_console_pkg.sv
// ============================================================================
//  Module   : dekatron_console_pkg
//  Purpose  : Shared types and helpers for the DekatronPC console UART.
//             Holds the digit width, the TX/RX state encodings and the
//             BCD <-> binary conversion functions.
//  Config   : `CONSOLE_PARITY_EN adds the PARITY state to both FSM encodings.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dekatron_console_pkg;

  localparam int DEKATRON_WIDTH = 4;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef CONSOLE_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef CONSOLE_PARITY_EN
    RX_PARITY = 3'd3,
`endif
    RX_STOP   = 3'd4
  } rx_state_t;

  // d2*100 + d1*10 + d0, digits taken as-is (no >9 check). The 12-bit
  // intermediate holds the worst case (all digits 15 -> 1665) before the
  // result is cut to 10 bits.
  function automatic logic [9:0] bcd3_to_bin(input logic [11:0] bcd);
    logic [11:0] acc;
    acc = (12'(bcd[11:8]) * 12'd100) + (12'(bcd[7:4]) * 12'd10) + 12'(bcd[3:0]);
    return acc[9:0];
  endfunction

  // Double-dabble: shift the byte into three BCD nibbles, adding 3 to any
  // nibble >= 5 before each shift.
  function automatic logic [11:0] byte_to_bcd3(input logic [7:0] b);
    logic [19:0] sr;
    sr = {12'd0, b};
    for (int i = 0; i < 8; i++) begin
      if (sr[11:8]  > 4'd4) sr[11:8]  = sr[11:8]  + 4'd3;
      if (sr[15:12] > 4'd4) sr[15:12] = sr[15:12] + 4'd3;
      if (sr[19:16] > 4'd4) sr[19:16] = sr[19:16] + 4'd3;
      sr = sr << 1;
    end
    return sr[19:8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/console_uart_rx.sv
// ============================================================================
//  Module   : console_uart_rx
//  Purpose  : UART receiver: 2-flop synchronizer, start-edge detect and
//             mid-bit sampling FSM. Presents the raw byte with one-cycle
//             combinational vld/err strobes in the stop-bit sample cycle.
//  Ports    : Clk, Rst_n (async, active-low)
//             rx_i     serial line in (asynchronous)
//             byte_o   assembled data byte (valid while vld_o)
//             vld_o    good frame strobe
//             err_o    framing (stop=0) or parity error strobe
//  Config   : `CONSOLE_PARITY_EN enables the even-parity bit check.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module console_uart_rx
  import dekatron_console_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       vld_o,
  output logic       err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic          sync1_q, sync2_q, prev_q;
  rx_state_t     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          par_err_q;

  logic w_fall, w_half, w_bit_end, w_stop_smp;

  // Idle-high reset so a released line does not look like a start edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign w_fall    = prev_q & ~sync2_q;
  assign w_half    = (cnt_q == CW'(CLKS_PER_BIT / 2 - 1));
  assign w_bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
    end else begin
      case (state_q)
        RX_IDLE: begin
          cnt_q     <= '0;
          par_err_q <= 1'b0;
          if (w_fall) state_q <= RX_START;
        end
        RX_START: begin
          if (w_half) begin
            cnt_q <= '0;
            bit_q <= '0;
            // Line back high at the midpoint: a glitch, not a start bit.
            state_q <= sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (w_bit_end) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) begin
`ifdef CONSOLE_PARITY_EN
              state_q <= RX_PARITY;
`else
              state_q <= RX_STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef CONSOLE_PARITY_EN
        RX_PARITY: begin
          if (w_bit_end) begin
            cnt_q     <= '0;
            par_err_q <= sync2_q ^ (^shift_q);
            state_q   <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          // Leave at the stop midpoint so the next start edge is caught.
          if (w_bit_end) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign w_stop_smp = (state_q == RX_STOP) && w_bit_end;
  assign byte_o     = shift_q;
  assign vld_o      = w_stop_smp & sync2_q & ~par_err_q;
  assign err_o      = w_stop_smp & (~sync2_q | par_err_q);

endmodule

`default_nettype wire

// File: rtl/dekatron_console_uart.sv
// ============================================================================
//  Module   : dekatron_console_uart
//  Purpose  : Console peer of the DekatronPC I/O port. BCD cells from the
//             core are converted to a byte (value mod 256) and sent 8N1;
//             received bytes are converted to 3-digit BCD for the core.
//  Ports    : Clk, Rst_n (async, active-low)
//             tx_data_bcd_i / tx_vld_i / tx_rdy_o   core -> line handshake
//             uart_tx_o                             serial out, idle high
//             uart_rx_i                             serial in, asynchronous
//             rx_data_bcd_o / rx_vld_o / rx_err_o   line -> core, pulses
//  Config   : `CONSOLE_PARITY_EN adds an even-parity bit (11-bit frames).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dekatron_console_uart
  import dekatron_console_pkg::*;
#(
  parameter int DIGITS         = 3,
  parameter int DEKATRON_WIDTH = 4,
  parameter int CLKS_PER_BIT   = 434
) (
  input  logic                             Clk,
  input  logic                             Rst_n,
  input  logic [DIGITS*DEKATRON_WIDTH-1:0] tx_data_bcd_i,
  input  logic                             tx_vld_i,
  output logic                             tx_rdy_o,
  output logic                             uart_tx_o,
  input  logic                             uart_rx_i,
  output logic [DIGITS*DEKATRON_WIDTH-1:0] rx_data_bcd_o,
  output logic                             rx_vld_o,
  output logic                             rx_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int DW = DIGITS * DEKATRON_WIDTH;

  // ---------------------------------------------------------------- TX
  tx_state_t     tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          tx_line_q;
  logic          tx_rdy_q;
`ifdef CONSOLE_PARITY_EN
  logic          tx_par_q;
`endif

  logic       w_tx_accept, w_tx_bit_end;
  logic [7:0] w_tx_byte;

  assign w_tx_byte    = 8'(bcd3_to_bin(tx_data_bcd_i));
  assign w_tx_accept  = tx_vld_i & tx_rdy_q;
  assign w_tx_bit_end = (tx_cnt_q == CW'(CLKS_PER_BIT - 1));

  // tx_rdy_q is only high in IDLE and in the last STOP cycle, so an accept
  // can override whatever the case statement would have done there.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      tx_rdy_q   <= 1'b1;
`ifdef CONSOLE_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else if (w_tx_accept) begin
      tx_state_q <= TX_START;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= w_tx_byte;
      tx_line_q  <= 1'b0;
      tx_rdy_q   <= 1'b0;
`ifdef CONSOLE_PARITY_EN
      tx_par_q   <= ^w_tx_byte;
`endif
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_cnt_q  <= '0;
          tx_line_q <= 1'b1;
          tx_rdy_q  <= 1'b1;
        end
        TX_START: begin
          if (w_tx_bit_end) begin
            tx_cnt_q   <= '0;
            tx_line_q  <= tx_shift_q[0];
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (w_tx_bit_end) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
`ifdef CONSOLE_PARITY_EN
              tx_line_q  <= tx_par_q;
              tx_state_q <= TX_PARITY;
`else
              tx_line_q  <= 1'b1;
              tx_state_q <= TX_STOP;
`endif
            end else begin
              tx_bit_q   <= tx_bit_q + 1'b1;
              tx_line_q  <= tx_shift_q[1];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
`ifdef CONSOLE_PARITY_EN
        TX_PARITY: begin
          if (w_tx_bit_end) begin
            tx_cnt_q   <= '0;
            tx_line_q  <= 1'b1;
            tx_state_q <= TX_STOP;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
`endif
        TX_STOP: begin
          // Ready one cycle early so a waiting cell starts right after STOP.
          if (tx_cnt_q == CW'(CLKS_PER_BIT - 2)) tx_rdy_q <= 1'b1;
          if (w_tx_bit_end) begin
            tx_cnt_q   <= '0;
            tx_state_q <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_rdy_o  = tx_rdy_q;
  assign uart_tx_o = tx_line_q;

  // ---------------------------------------------------------------- RX
  logic [7:0]    w_rx_byte;
  logic          w_rx_vld, w_rx_err;
  logic [DW-1:0] rx_data_bcd_q, rx_data_bcd_d;
  logic          rx_vld_q, rx_vld_d;
  logic          rx_err_q, rx_err_d;

  console_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .rx_i   (uart_rx_i),
    .byte_o (w_rx_byte),
    .vld_o  (w_rx_vld),
    .err_o  (w_rx_err)
  );

  always_comb begin
    rx_data_bcd_d = rx_data_bcd_q;
    rx_vld_d      = w_rx_vld;
    rx_err_d      = w_rx_err;
    if (w_rx_vld) rx_data_bcd_d = byte_to_bcd3(w_rx_byte);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_data_bcd_q <= '0;
      rx_vld_q      <= 1'b0;
      rx_err_q      <= 1'b0;
    end else begin
      rx_data_bcd_q <= rx_data_bcd_d;
      rx_vld_q      <= rx_vld_d;
      rx_err_q      <= rx_err_d;
    end
  end

  assign rx_data_bcd_o = rx_data_bcd_q;
  assign rx_vld_o      = rx_vld_q;
  assign rx_err_o      = rx_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dekatron_console_uart.sv
// ============================================================================
//  Module   : tb_dekatron_console_uart
//  Purpose  : Scoreboard bench for dekatron_console_uart (CLKS_PER_BIT=8).
//             Expected TX bytes / RX BCD values are queued by the stimulus
//             and popped by independent line and rx_vld monitors.
//  Config   : honours `CONSOLE_PARITY_EN like the design.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dekatron_console_uart;

  localparam int CPB = 8;
`ifdef CONSOLE_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic [11:0] tx_data = '0;
  logic        tx_vld  = 1'b0;
  logic        rx_line = 1'b1;
  logic        tx_rdy, tx_line, rx_vld, rx_err;
  logic [11:0] rx_data;

  int vectors     = 0;
  int miscompares = 0;
  int exp_err     = 0;
  int seen_err    = 0;
  bit seen_reset  = 1'b0;

  logic [7:0]  tx_q[$];
  logic [11:0] rx_q[$];
  logic [11:0] rx_exp;

  always #5 clk = ~clk;

  dekatron_console_uart #(
    .DIGITS         (3),
    .DEKATRON_WIDTH (4),
    .CLKS_PER_BIT   (CPB)
  ) dut (
    .Clk           (clk),
    .Rst_n         (rst_n),
    .tx_data_bcd_i (tx_data),
    .tx_vld_i      (tx_vld),
    .tx_rdy_o      (tx_rdy),
    .uart_tx_o     (tx_line),
    .uart_rx_i     (rx_line),
    .rx_data_bcd_o (rx_data),
    .rx_vld_o      (rx_vld),
    .rx_err_o      (rx_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge rst_n) seen_reset = 1'b1;

  // ---------------- TX line monitor: decode each frame at bit midpoints
  initial begin : tx_mon
    logic [7:0] b;
    logic       st, stp, par;
    logic [7:0] e;
    par = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_line === 1'b0) begin
        seen_reset = 1'b0;
        repeat (3) @(negedge clk);
        st = tx_line;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx_line;
        end
`ifdef CONSOLE_PARITY_EN
        repeat (CPB) @(negedge clk);
        par = tx_line;
`endif
        repeat (CPB) @(negedge clk);
        stp = tx_line;
        if (!seen_reset) begin
          if (tx_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL tx_unexpected_frame: got byte %0h, required no frame", b);
          end else begin
            e = tx_q.pop_front();
            check("tx_start_bit", {31'd0, st}, 32'd0);
            check("tx_byte", {24'd0, b}, {24'd0, e});
`ifdef CONSOLE_PARITY_EN
            check("tx_parity_bit", {31'd0, par}, {31'd0, ^e});
`endif
            check("tx_stop_bit", {31'd0, stp}, 32'd1);
          end
        end
      end
    end
  end

  // ---------------- RX output monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_vld === 1'b1) begin
        if (rx_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rx_unexpected_vld: got %0h, required no pulse", rx_data);
        end else begin
          rx_exp = rx_q.pop_front();
          check("rx_bcd", {20'd0, rx_data}, {20'd0, rx_exp});
        end
      end
      if (rx_err === 1'b1) seen_err++;
    end
  end

  // Offer a cell; returns on the negedge just after the accepting posedge.
  task automatic send_cell(input logic [11:0] d);
    int n;
    n = 0;
    tx_data = d;
    tx_vld  = 1'b1;
    while (tx_rdy !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      vectors++;
      miscompares++;
      $display("FAIL tx_accept_timeout: got tx_rdy=%0b, required 1", tx_rdy);
    end
    @(negedge clk);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop, input logic par_flip);
    rx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef CONSOLE_PARITY_EN
    rx_line = (^b) ^ par_flip;
    repeat (CPB) @(negedge clk);
`endif
    rx_line = stop;
    repeat (CPB) @(negedge clk);
    rx_line = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    // 1: reset values, then 12'h065 -> 8'h41
    repeat (3) @(negedge clk);
    check("rst_tx_rdy",  {31'd0, tx_rdy},  32'd1);
    check("rst_uart_tx", {31'd0, tx_line}, 32'd1);
    check("rst_rx_data", {20'd0, rx_data}, 32'd0);
    check("rst_rx_vld",  {31'd0, rx_vld},  32'd0);
    check("rst_rx_err",  {31'd0, rx_err},  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    tx_q.push_back(8'h41);
    send_cell(12'h065);
    tx_vld = 1'b0;
    n = 0;
    while (tx_rdy !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("tx_rdy_low_cycles", n, FRAME_BITS * CPB - 1);
    check("tx_line_last_stop", {31'd0, tx_line}, 32'd1);
    repeat (CPB + 4) @(negedge clk);

    // 2: 300 -> 8'h2C, then 010 -> 8'h0A back-to-back
    tx_q.push_back(8'h2C);
    tx_q.push_back(8'h0A);
    send_cell(12'h300);
    send_cell(12'h010);
    check("b2b_start_follows_stop", {31'd0, tx_line}, 32'd0);
    check("b2b_rdy_dropped", {31'd0, tx_rdy}, 32'd0);
    tx_vld = 1'b0;
    repeat (FRAME_BITS * CPB + 8) @(negedge clk);

    // 3: RX conversions
    rx_q.push_back(12'h255);
    rx_frame(8'hFF, 1'b1, 1'b0);
    rx_q.push_back(12'h123);
    rx_frame(8'h7B, 1'b1, 1'b0);
    rx_q.push_back(12'h000);
    rx_frame(8'h00, 1'b1, 1'b0);

    // 4: 3-cycle glitch is ignored; stop=0 raises one error, data held
    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    rx_line = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_no_err", seen_err, 32'd0);
    rx_frame(8'h55, 1'b0, 1'b0);
    exp_err++;
    check("err_rx_data_held", {20'd0, rx_data}, 32'h000);
    check("err_pulse_count", seen_err, 32'd1);

    // 5: reset during TX/RX data bit 4
    tx_data = 12'h123;
    tx_vld  = 1'b1;
    rx_line = 1'b0;
    @(negedge clk);
    tx_vld = 1'b0;
    repeat (5 * CPB + 3) @(negedge clk);
    rst_n   = 1'b0;
    rx_line = 1'b1;
    #1;
    check("midrst_uart_tx", {31'd0, tx_line}, 32'd1);
    check("midrst_tx_rdy",  {31'd0, tx_rdy},  32'd1);
    check("midrst_rx_data", {20'd0, rx_data}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);

    // TX and RX running together after reset
    tx_q.push_back(8'h7B);
    send_cell(12'h123);
    tx_vld = 1'b0;
    rx_q.push_back(12'h123);
    rx_frame(8'h7B, 1'b1, 1'b0);
    repeat (16) @(negedge clk);

`ifdef CONSOLE_PARITY_EN
    // 6: parity frames
    tx_q.push_back(8'h41);
    send_cell(12'h065);
    tx_vld = 1'b0;
    repeat (FRAME_BITS * CPB + 8) @(negedge clk);
    tx_q.push_back(8'h07);
    send_cell(12'h007);
    tx_vld = 1'b0;
    repeat (FRAME_BITS * CPB + 8) @(negedge clk);
    rx_frame(8'h41, 1'b1, 1'b1);
    exp_err++;
`endif

    repeat (20) @(negedge clk);
    check("tx_queue_drained", tx_q.size(), 32'd0);
    check("rx_queue_drained", rx_q.size(), 32'd0);
    check("rx_err_total", seen_err, exp_err);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
